// File: rtl/ex_div_unit_pkg.sv
// rtl/ex_div_unit_pkg.sv - shared constants and state encoding for the EX-stage divider
package ex_div_unit_pkg;

    localparam int DIV_W        = 32;
    localparam int STALL_BUS_W  = 6;
    localparam int EX_STALL_BIT = 3;

    // Quotient reported for any divide by zero, signed or unsigned.
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - EX-stage divide request, controller stall/flush and result bundle
// master: EX stage / pipeline controller side (drives request, flush, stall)
// slave : divider side (drives stallreq_es, div_q, div_r, div_ready)
interface ex_div_unit_if #(
    parameter int DIV_W       = ex_div_unit_pkg::DIV_W,
    parameter int STALL_BUS_W = ex_div_unit_pkg::STALL_BUS_W
);
    logic                   div_en;
    logic                   div_signed;
    logic [DIV_W-1:0]       op_a;
    logic [DIV_W-1:0]       op_b;
    logic                   flush;
    logic [STALL_BUS_W-1:0] stall;
    logic                   stallreq_es;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_r;
    logic                   div_ready;

    modport master (
        output div_en, div_signed, op_a, op_b, flush, stall,
        input  stallreq_es, div_q, div_r, div_ready
    );

    modport slave (
        input  div_en, div_signed, op_a, op_b, flush, stall,
        output stallreq_es, div_q, div_r, div_ready
    );

endinterface

// File: rtl/ex_div_unit_div_step.sv
// rtl/ex_div_unit_div_step.sv - one combinational restoring-division iteration
// rem_in  : {partial remainder, remaining dividend / collected quotient bits}
// divisor : unsigned divisor magnitude
// rem_out : shifted remainder, upper half reduced when the trial subtract succeeds (bit 0 left clear)
// q_bit   : quotient bit produced by this iteration
module div_step #(
    parameter int DIV_W = ex_div_unit_pkg::DIV_W
) (
    input  logic [2*DIV_W-1:0] rem_in,
    input  logic [DIV_W-1:0]   divisor,
    output logic [2*DIV_W-1:0] rem_out,
    output logic               q_bit
);

    // Upper half after the left shift needs one extra bit, since the
    // previous partial remainder can be as large as divisor-1.
    logic [DIV_W:0] trial;
    logic [DIV_W:0] diff;

    assign trial   = rem_in[2*DIV_W-1:DIV_W-1];
    assign diff    = trial - {1'b0, divisor};
    assign q_bit   = ~diff[DIV_W];
    assign rem_out = q_bit ? {diff[DIV_W-1:0], rem_in[DIV_W-2:0], 1'b0}
                           : {rem_in[2*DIV_W-2:0], 1'b0};

endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - multi-cycle 32-bit divider and EX-stage stall requester
// clk, resetn (async active-low); bus (slave): div_en/div_signed/op_a/op_b request,
// flush/stall from the controller, stallreq_es (combinational), div_q/div_r (registered), div_ready.
// Optional macro DIV_FAST_PATH_EN: finish divide-by-zero and |a| < |b| in the start cycle.
module ex_div_unit #(
    parameter int DIV_W        = ex_div_unit_pkg::DIV_W,
    parameter int EX_STALL_BIT = ex_div_unit_pkg::EX_STALL_BIT
) (
    input  logic         clk,
    input  logic         resetn,
    ex_div_unit_if.slave bus
);
    import ex_div_unit_pkg::*;

    localparam logic [5:0] LAST_STEP = 6'(DIV_W - 1);

    div_state_e         state, state_nxt;
    logic [5:0]         cnt;
    logic [2*DIV_W-1:0] rem, rem_nxt, step_rem;
    logic               step_q_bit;
    logic [DIV_W-1:0]   divisor, abs_a, abs_b, q_fin, r_fin, q_reg, r_reg;
    logic               a_neg, b_neg, q_neg, r_neg;
    logic               start, fast_take, stallreq, ready;

    assign a_neg = bus.div_signed & bus.op_a[DIV_W-1];
    assign b_neg = bus.div_signed & bus.op_b[DIV_W-1];
    assign abs_a = a_neg ? -bus.op_a : bus.op_a;
    assign abs_b = b_neg ? -bus.op_b : bus.op_b;
    assign start = (state == ST_IDLE) & bus.div_en & ~bus.flush;

`ifdef DIV_FAST_PATH_EN
    assign fast_take = (bus.op_b == '0) || (abs_a < abs_b);
`else
    assign fast_take = 1'b0;
`endif

    div_step #(.DIV_W(DIV_W)) u_div_step (
        .rem_in  (rem),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q_bit)
    );

    // Quotient bits accumulate in the low half; after the last step the
    // upper half is the remainder magnitude.
    assign rem_nxt = step_rem | {{(2*DIV_W-1){1'b0}}, step_q_bit};
    assign q_fin   = q_neg ? -rem_nxt[DIV_W-1:0]       : rem_nxt[DIV_W-1:0];
    assign r_fin   = r_neg ? -rem_nxt[2*DIV_W-1:DIV_W] : rem_nxt[2*DIV_W-1:DIV_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.div_en) state_nxt = fast_take ? ST_DONE : ST_BUSY;
                ST_BUSY: if (cnt == LAST_STEP) state_nxt = ST_DONE;
                // Only leave once the instruction actually advances out of EX.
                ST_DONE: if (!bus.stall[EX_STALL_BIT]) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // stallreq_es never looks at stall, so the controller sees no loop.
    always_comb begin
        stallreq = 1'b0;
        ready    = 1'b0;
        case (state)
            ST_IDLE: stallreq = bus.div_en & ~bus.flush;
            ST_BUSY: stallreq = ~bus.flush;
            ST_DONE: ready    = 1'b1;
            default: ;
        endcase
        if (!resetn) stallreq = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            q_reg   <= '0;
            r_reg   <= '0;
        end else if (start) begin
            cnt     <= '0;
            rem     <= {{DIV_W{1'b0}}, abs_a};
            divisor <= abs_b;
            // Divide by zero keeps the all-ones quotient unsigned; the
            // remainder magnitude |a| re-signed gives back op_a.
            q_neg   <= (a_neg ^ b_neg) & (bus.op_b != '0);
            r_neg   <= a_neg;
            if (fast_take) begin
                q_reg <= (bus.op_b == '0) ? DIV_ZERO_Q : '0;
                r_reg <= bus.op_a;
            end
        end else if (state == ST_BUSY && !bus.flush) begin
            cnt <= cnt + 6'd1;
            rem <= rem_nxt;
            if (cnt == LAST_STEP) begin
                q_reg <= q_fin;
                r_reg <= r_fin;
            end
        end
    end

    assign bus.stallreq_es = stallreq;
    assign bus.div_ready   = ready;
    assign bus.div_q       = q_reg;
    assign bus.div_r       = r_reg;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - directed self-checking bench for ex_div_unit
module tb_ex_div_unit;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ex_div_unit_if bus ();

    ex_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef DIV_FAST_PATH_EN
    localparam int FAST_RDY = 1;
    localparam int FAST_STL = 1;
`else
    localparam int FAST_RDY = 33;
    localparam int FAST_STL = 33;
`endif

    int checks = 0;
    int errors = 0;
    int stl_cnt;
    int rdy_cyc;
    int hits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the divider idle; returns at the
    // falling edge of the first cycle with div_ready high (or after the budget).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int stall_cycles, output int ready_cycle);
        bus.div_signed = sgn;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.div_en     = 1'b1;
        stall_cycles   = 0;
        ready_cycle    = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.stallreq_es === 1'b1) stall_cycles++;
            if (bus.div_ready === 1'b1) begin
                ready_cycle = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Let the instruction leave EX and spend one idle cycle.
    task automatic leave_ex();
        bus.stall = '0;
        @(posedge clk); #1;
        bus.div_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic div_case(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                            input int exp_rdy, input int exp_stl);
        run_div(sgn, a, b, stl_cnt, rdy_cyc);
        check({tag, "_ready_cycle"}, rdy_cyc, exp_rdy);
        check({tag, "_stall_cycles"}, stl_cnt, exp_stl);
        check({tag, "_q"}, bus.div_q, eq);
        check({tag, "_r"}, bus.div_r, er);
        leave_ex();
    endtask

    initial begin
        resetn         = 1'b0;
        bus.div_en     = 1'b0;
        bus.div_signed = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.flush      = 1'b0;
        bus.stall      = '0;
        #2;
        check("rst_stallreq", bus.stallreq_es, 0);
        check("rst_ready", bus.div_ready, 0);
        check("rst_q", bus.div_q, 0);
        check("rst_r", bus.div_r, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        div_case("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33);
        div_case("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 33);
        div_case("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 33);
        div_case("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, FAST_RDY, FAST_STL);
        div_case("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, FAST_RDY, FAST_STL);
        div_case("s-3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, FAST_RDY, FAST_STL);
        div_case("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 33);
        div_case("uFFFF_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 33, 33);

        // Flush in BUSY cycle 10.
        bus.div_signed = 1'b0;
        bus.op_a       = 32'd100;
        bus.op_b       = 32'd7;
        bus.div_en     = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.flush  = 1'b1;
        bus.div_en = 1'b0;
        @(negedge clk);
        check("flush_stallreq_gated", bus.stallreq_es, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_idle_stallreq", bus.stallreq_es, 0);
        hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.div_ready !== 1'b0) hits++;
        end
        check("flush_no_ready", hits, 0);
        div_case("post_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33);

        // Held in DONE by another stall source.
        run_div(1'b0, 32'd1000, 32'd3, stl_cnt, rdy_cyc);
        check("hold_ready_cycle", rdy_cyc, 33);
        bus.stall = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_ready", bus.div_ready, 1);
            check("hold_stallreq", bus.stallreq_es, 0);
            check("hold_q", bus.div_q, 32'd333);
            check("hold_r", bus.div_r, 32'd1);
        end
        @(negedge clk);
        bus.stall = '0;
        @(posedge clk); #1;
        bus.div_en = 1'b0;
        check("hold_release_ready", bus.div_ready, 0);
        check("hold_release_q", bus.div_q, 32'd333);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of BUSY.
        bus.div_signed = 1'b1;
        bus.op_a       = 32'd12345;
        bus.op_b       = 32'd77;
        bus.div_en     = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("busy_stallreq", bus.stallreq_es, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_stallreq", bus.stallreq_es, 0);
        check("arst_ready", bus.div_ready, 0);
        check("arst_q", bus.div_q, 0);
        check("arst_r", bus.div_r, 0);
        bus.div_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_rst_stallreq", bus.stallreq_es, 0);
        check("post_rst_ready", bus.div_ready, 0);
        check("post_rst_q", bus.div_q, 0);
        div_case("post_rst", 1'b1, 32'd12345, 32'd77, 32'd160, 32'd25, 33, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Multi-cycle 32-bit integer divider in the EX stage and the requester side of the pipeline stall interface. It accepts a divide from the EX instruction and raises `stallreq_es` while iterating, which holds IF..EX. It honours the `stall`/`flush` vectors driven back by the pipeline controller, and holds its result until the EX instruction actually advances.

## Interface
- `DIV_W`, 32: operand/result width
- `EX_STALL_BIT`, 3: index in `stall` that holds the EX stage
- `clk` input 1: clock
- `resetn` input 1: asynchronous, active-low reset
- `div_en` input 1: EX instruction is a div/mod; level, held while EX is stalled
- `div_signed` input 1: 1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
- `op_a` input DIV_W: dividend
- `op_b` input DIV_W: divisor
- `flush` input 1: pipeline flush from controller
- `stall` input 6: stall vector from controller
- `stallreq_es` output 1: stall request to controller (combinational)
- `div_q` output DIV_W: quotient (registered)
- `div_r` output DIV_W: remainder (registered)
- `div_ready` output 1: `div_q`/`div_r` valid for the current EX instruction

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - `div_en & !flush`: latch |op_a|, |op_b|, quotient sign (a^b, signed only), remainder sign (a, signed only) and signed flag; clear 6-bit counter; go to BUSY.
  - `stallreq_es = div_en & !flush`, asserted in this start cycle.
- **BUSY**
  - One restoring step per cycle on a 64-bit partial remainder: shift left 1, subtract divisor<<32; if non-negative keep it and set quotient bit, else restore.
  - After 32 steps (counter 0..31), go to DONE.
  - `stallreq_es = !flush`.
- **DONE**
  - `div_q`/`div_r` are loaded on the BUSY->DONE edge, with sign correction applied (negate when the sign flag is set).
  - `div_ready = 1`, `stallreq_es = 0`.
  - Return to IDLE when `stall[EX_STALL_BIT] == 0`, i.e. the instruction leaves EX. While it is stalled by other causes (axi/cache), stay in DONE and do not restart, even though `div_en` is still high.
- **Arithmetic rules**
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - op_b = 0: `div_q = 32'hFFFF_FFFF`, `div_r = op_a`, with no sign correction, in signed and unsigned modes.
  - 0x8000_0000 / -1 signed: `div_q = 32'h8000_0000`, `div_r = 0`.
- **Flush and reset**
  - `flush` in any state: go to IDLE next cycle, clear `div_ready`; `stallreq_es` is gated low in the same cycle.
  - `flush` in the same cycle as `div_en` in IDLE: no start.
  - `resetn` low at any time, including mid-BUSY: immediately IDLE. Outputs `stallreq_es=0`, `div_ready=0`, `div_q=0`, `div_r=0`; counter 0.

## Timing
- Start cycle 0 (IDLE, `div_en`). BUSY occupies cycles 1..32. DONE is cycle 33, where `div_ready=1`.
- `stallreq_es` is high for cycles 0..32, i.e. 33 cycles.
- Back-to-back divides: the next start is in the cycle after DONE->IDLE, so there is at least one IDLE cycle between operations.
- `stallreq_es` depends combinationally only on state, `div_en` and `flush`. It never depends on `stall`, so there is no combinational loop through the controller.

## Configuration
- `DIV_FAST_PATH_EN`
  - **Defined**: in IDLE, if op_b == 0 or |op_a| < |op_b|, skip BUSY and go directly to DONE with the results computed in the start cycle (q = 0 and r = op_a; or the divide-by-zero values). Stall is 1 cycle, and `div_ready` is high in cycle 1.
  - **Undefined**: every divide takes the full 33-cycle stall path. Results are identical in both builds.

## Structure
- Shared package holds:
  - the state encoding (IDLE/BUSY/DONE)
  - `DIV_W`
  - `STALL_BUS_W = 6`
  - `EX_STALL_BIT = 3`
  - the divide-by-zero result constant
- One sub-module, `div_step`: combinational single restoring iteration (64-bit remainder, divisor in; next remainder and quotient bit out). It is instantiated once and used by the FSM each BUSY cycle.

## Test plan
- Unsigned 100 / 7, stall=0 -> `stallreq_es` high 33 cycles; cycle 33: `div_q=14`, `div_r=2`, `div_ready=1`.
- Signed -7 / 2 -> `div_q=32'hFFFF_FFFD` (-3), `div_r=32'hFFFF_FFFF` (-1). Signed 0x8000_0000 / 0xFFFF_FFFF -> `div_q=0x8000_0000`, `div_r=0`.
- Divide by zero, op_a=5, signed -> `div_q=0xFFFF_FFFF`, `div_r=5`. With `DIV_FAST_PATH_EN` defined, `div_ready` is high in cycle 1.
- `flush` pulsed at cycle 10 of BUSY -> `stallreq_es` low that cycle; IDLE next; `div_ready` never asserts. A fresh divide then completes correctly.
- DONE with `stall[3]` held high 5 extra cycles -> `div_ready` and results stable, no restart, `stallreq_es` stays 0. IDLE the cycle after `stall[3]` drops.
- `resetn` asserted mid-BUSY -> all outputs 0 asynchronously. After release with `div_en` low, the block stays IDLE.
